// File: rtl/fetch_unit_if.sv
// Fetch unit bus interface: branch/halt/stall controls and instruction
// memory read data in, fetch address and IF/ID pipeline register out.
// With FETCH_PERF_CNT_EN defined, FetchCount/RedirectCount are added.
interface fetch_unit_if #(
    parameter int PC_WIDTH = 9
);
    logic                PCSel;
    logic [31:0]         PCBranch;
    logic                Halt;
    logic                Stall;
    logic [31:0]         Instr;
    logic [PC_WIDTH-1:0] PC;
    logic [PC_WIDTH-1:0] IFID_PC;
    logic [31:0]         IFID_Instr;
    logic                IFID_Valid;
    logic                Halted;
    logic                MisalignErr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]         FetchCount;
    logic [31:0]         RedirectCount;

    modport master (
        output PCSel, PCBranch, Halt, Stall, Instr,
        input  PC, IFID_PC, IFID_Instr, IFID_Valid, Halted, MisalignErr,
        input  FetchCount, RedirectCount
    );
    modport slave (
        input  PCSel, PCBranch, Halt, Stall, Instr,
        output PC, IFID_PC, IFID_Instr, IFID_Valid, Halted, MisalignErr,
        output FetchCount, RedirectCount
    );
`else
    modport master (
        output PCSel, PCBranch, Halt, Stall, Instr,
        input  PC, IFID_PC, IFID_Instr, IFID_Valid, Halted, MisalignErr
    );
    modport slave (
        input  PCSel, PCBranch, Halt, Stall, Instr,
        output PC, IFID_PC, IFID_Instr, IFID_Valid, Halted, MisalignErr
    );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// RUN/HALTED FSM. Redirects take priority over halt, halt over stall.
// A misaligned redirect target sets a sticky error and halts; only reset
// leaves HALTED. Optional macro FETCH_PERF_CNT_EN adds fetch/redirect counters.
module fetch_unit #(
    parameter int          PC_WIDTH  = 9,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input logic        clk,
    input logic        reset,
    fetch_unit_if.slave bus
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] ifpc_q, ifpc_d;
    logic [31:0]         ifinstr_q, ifinstr_d;
    logic                ifvalid_q, ifvalid_d;
    logic                err_q, err_d;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]         fcnt_q, fcnt_d;
    logic [31:0]         rcnt_q, rcnt_d;
`endif

    // Upper redirect bits beyond the PC width are deliberately dropped.
    logic unused_branch_bits;
    assign unused_branch_bits = ^bus.PCBranch;

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= '0;
            ifpc_q    <= '0;
            ifinstr_q <= NOP_INSTR;
            ifvalid_q <= 1'b0;
            err_q     <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            fcnt_q    <= '0;
            rcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ifpc_q    <= ifpc_d;
            ifinstr_q <= ifinstr_d;
            ifvalid_q <= ifvalid_d;
            err_q     <= err_d;
`ifdef FETCH_PERF_CNT_EN
            fcnt_q    <= fcnt_d;
            rcnt_q    <= rcnt_d;
`endif
        end
    end

    // Next-state and next-register selection: redirect > halt > stall > fetch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ifpc_d    = ifpc_q;
        ifinstr_d = ifinstr_q;
        ifvalid_d = ifvalid_q;
        err_d     = err_q;
`ifdef FETCH_PERF_CNT_EN
        fcnt_d    = fcnt_q;
        rcnt_d    = rcnt_q;
`endif
        case (state_q)
            RUN: begin
                if (bus.PCSel) begin
                    ifpc_d    = '0;
                    ifinstr_d = NOP_INSTR;
                    ifvalid_d = 1'b0;
                    if (bus.PCBranch[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                    end else begin
                        pc_d = bus.PCBranch[PC_WIDTH-1:0];
`ifdef FETCH_PERF_CNT_EN
                        rcnt_d = rcnt_q + 32'd1;
`endif
                    end
                end else if (bus.Halt) begin
                    ifpc_d    = '0;
                    ifinstr_d = NOP_INSTR;
                    ifvalid_d = 1'b0;
                    state_d   = HALTED;
                end else if (!bus.Stall) begin
                    ifpc_d    = pc_q;
                    ifinstr_d = bus.Instr;
                    ifvalid_d = 1'b1;
                    pc_d      = pc_q + PC_WIDTH'(4);
`ifdef FETCH_PERF_CNT_EN
                    fcnt_d    = fcnt_q + 32'd1;
`endif
                end
            end
            HALTED: begin
                ifpc_d    = '0;
                ifinstr_d = NOP_INSTR;
                ifvalid_d = 1'b0;
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.PC          = pc_q;
    assign bus.IFID_PC     = ifpc_q;
    assign bus.IFID_Instr  = ifinstr_q;
    assign bus.IFID_Valid  = ifvalid_q;
    assign bus.Halted      = (state_q == HALTED);
    assign bus.MisalignErr = err_q;
`ifdef FETCH_PERF_CNT_EN
    assign bus.FetchCount    = fcnt_q;
    assign bus.RedirectCount = rcnt_q;
`endif

endmodule
